// File: rtl/dtw_pkg.sv
// dtw_pkg
//   Constants and types shared by the DTW core, its reference memory and
//   the reference loader.
//   DTW_WIDTH      : quantised sample width (reference memory data width)
//   DTW_PTR_WID    : reference memory address width
//   ref_ld_state_t : reference loader FSM state
package dtw_pkg;

  localparam int DTW_WIDTH   = 16;
  localparam int DTW_PTR_WID = 15;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } ref_ld_state_t;

endpackage

// File: rtl/dtw_ref_loader.sv
// dtw_ref_loader
//   Fills the DTW reference memory from a valid/ready sample stream that is
//   terminated by s_last. Samples land at sequential addresses from 0.
//   Beats arriving once the memory is full are accepted and discarded so the
//   source can drain; that case raises a sticky overflow flag.
//
//   Ports
//     clk, rst_n          clock, asynchronous active-low reset
//     start               begin a new load (honoured only in IDLE)
//     s_data/s_valid/
//     s_last/s_ready      incoming sample stream
//     mem_addrW/mem_wren/
//     mem_datain          reference memory write port (registered)
//     ref_len             samples stored by the last completed load
//     busy                high whenever not IDLE
//     done                one-cycle pulse at the end of a load
//     overflow            sticky: a beat was dropped because memory was full
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; ref_len holds the previous result
//   LOAD  | accepting beats, writing while count < DEPTH
//   FLUSH | last write is on the memory port this cycle
//   DONE  | done pulse, ref_len valid, all samples committed
module dtw_ref_loader
  import dtw_pkg::*;
#(
  parameter int WIDTH   = DTW_WIDTH,
  parameter int PTR_WID = DTW_PTR_WID,
  parameter int DEPTH   = 2**PTR_WID
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   s_data,
  input  logic               s_valid,
  input  logic               s_last,
  output logic               s_ready,
  output logic [PTR_WID-1:0] mem_addrW,
  output logic               mem_wren,
  output logic [WIDTH-1:0]   mem_datain,
  output logic [PTR_WID:0]   ref_len,
  output logic               busy,
  output logic               done,
  output logic               overflow
);

  localparam logic [PTR_WID:0] DEPTH_CNT = (PTR_WID+1)'(DEPTH);

  ref_ld_state_t        state;
  logic [PTR_WID-1:0]   wr_ptr;
  logic [PTR_WID:0]     count;
  logic                 accept;
  logic                 has_room;

  // s_ready is only ever high in LOAD, so accept implies LOAD.
  assign accept   = s_valid && s_ready;
  assign has_room = (count < DEPTH_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      count      <= '0;
      s_ready    <= 1'b0;
      mem_addrW  <= '0;
      mem_wren   <= 1'b0;
      mem_datain <= '0;
      ref_len    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      mem_wren <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= LOAD;
            s_ready  <= 1'b1;
            busy     <= 1'b1;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            if (has_room) begin
              mem_addrW  <= wr_ptr;
              mem_datain <= s_data;
              mem_wren   <= 1'b1;
              wr_ptr     <= wr_ptr + PTR_WID'(1);
              count      <= count + (PTR_WID+1)'(1);
            end else begin
              overflow <= 1'b1;
            end
            if (s_last) begin
              state   <= FLUSH;
              s_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          // count is final here; latch it so ref_len is valid alongside done.
          state   <= DONE;
          done    <= 1'b1;
          ref_len <= count;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          s_ready <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/dtw_ref_loader.md
# dtw_ref_loader

Stream-to-BRAM loader that fills the DTW core's reference memory with quantised reference samples. It sits directly upstream of the reference memory. It accepts a valid/ready sample stream terminated by a last flag and drives the memory's write port (`addrW`, `wren`, `datain`) with sequential addresses from 0. It reports the loaded reference length, with done and overflow status, to the DTW control logic.

## Interface
Parameters:
- `WIDTH`, 16: sample width; must match the reference memory's data width.
- `PTR_WID`, 15: memory address width.
- `DEPTH`, 2**PTR_WID: memory capacity in samples.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a new load; honoured only in IDLE.
- `s_data`  in  WIDTH  incoming reference sample.
- `s_valid`  in  1  `s_data` and `s_last` are valid.
- `s_last`  in  1  current beat is the final sample of the reference.
- `s_ready`  out  1  loader accepts a beat this cycle.
- `mem_addrW`  out  PTR_WID  write address to the reference memory.
- `mem_wren`  out  1  write enable to the reference memory.
- `mem_datain`  out  WIDTH  write data to the reference memory.
- `ref_len`  out  PTR_WID+1  number of samples stored by the last completed load (0..DEPTH).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  single-cycle pulse when a load completes.
- `overflow`  out  1  sticky flag: at least one beat was dropped because the memory was full.

## Operation
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - `s_ready`=0.
  - `start`=1 → LOAD; clears `wr_ptr`, `count` and `overflow`.
  - `ref_len` keeps the value from the previous load.
- LOAD:
  - `s_ready`=1; a beat is accepted when `s_valid && s_ready`.
  - If `count < DEPTH`, the accepted beat is written: `mem_addrW`←`wr_ptr`, `mem_datain`←`s_data`, `mem_wren`←1 (all registered). Then `wr_ptr`++ and `count`++.
  - If `count == DEPTH`, the beat is dropped: no write, and `overflow`←1. The loader keeps accepting beats until `s_last` so the source drains.
  - An accepted beat with `s_last`=1 → FLUSH (the beat itself is written or dropped as above).
- FLUSH:
  - `s_ready`=0; the final write is on the memory port this cycle. → DONE.
- DONE:
  - `done`=1 for this cycle only; `ref_len` is loaded with `count`. → IDLE.
- `wr_ptr` is PTR_WID bits. It wraps to 0 after writing address DEPTH-1, but no write is issued once `count == DEPTH`, so no address is ever overwritten within one load.
- `count` is PTR_WID+1 bits, so a full load reports `ref_len` = DEPTH exactly.
- `start` in LOAD, FLUSH or DONE is ignored; it is not queued.
- `mem_wren` is 0 in every cycle except the one following a written beat.
- Reset, asynchronous, at any point including mid-load:
  - state→IDLE.
  - `s_ready`, `mem_wren`, `mem_addrW`, `mem_datain`, `ref_len`, `busy`, `done`, `overflow` all → 0.
  - Memory contents from a partial load are undefined to downstream logic.

## Timing
- Beat accepted at edge E0 → `mem_wren`/`mem_addrW`/`mem_datain` valid during the cycle after E0 → memory commits at E1.
- Back-to-back acceptance gives one write per cycle; throughput is 1 sample/clk while `s_valid` is held high.
- Last beat accepted at E0 → FLUSH in the cycle after E0 → DONE (`done`=1, `ref_len` valid) in the cycle after E1 → IDLE after E2.
- When `done` is seen, every sample is already committed in memory, so the DTW core may read from that cycle on.
- `start` sampled at E0 in IDLE → `s_ready`=1 in the cycle after E0.
- Minimum load, one beat with `s_last`: `busy` is high for 3 cycles.

## Structure
- Shared package `dtw_pkg`:
  - `DTW_WIDTH`=16 and `DTW_PTR_WID`=15 constants, shared with the reference memory.
  - The loader state enum `ref_ld_state_t` (IDLE, LOAD, FLUSH, DONE).
- Single module, no sub-modules: a small FSM plus pointer and counter registers.

## Test plan
- Reset, then `start`, then 4 beats 0x0011, 0x0022, 0x0033, 0x0044 (last on the 4th) → writes to addresses 0..3 with those values, `done` pulse, `ref_len`=4, `overflow`=0.
- Source toggles `s_valid` 1,0,1,0 over 3 beats → exactly 3 writes at addresses 0,1,2; `mem_wren` is never asserted in idle-valid cycles.
- DEPTH=8 build; send 10 beats with last on the 10th → addresses 0..7 written, beats 9–10 dropped, `overflow`=1, `ref_len`=8, address 0 still holds beat 1.
- `start` pulsed during LOAD, then a new load of 2 beats after `done` → first start ignored mid-load; the second load rewrites addresses 0–1, `ref_len`=2, `overflow` cleared.
- `rst_n` asserted after 5 of 10 beats → all outputs 0 immediately (asynchronous), state IDLE, `s_ready`=0 until the next `start`.
- Single-beat load → `busy` high for exactly 3 cycles, `done` in the 3rd, `ref_len`=1.
